alu_issue_seq: RTL and testbench

Sequencing front end for the 8-bit `alu` datapath. It accepts one instruction at a time over a valid/ready handshake and reads operands from a local 4 x 8-bit register file. It drives registered `S`/`Cin`/`A`/`B` into the combinational `alu`, captures `Y`, writes the result back to the register file, and presents it downstream with a zero flag.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/alu_regfile.sv | 48 ++++
 rtl/alu_issue_seq.sv | 157 +++++++++++++++
 tb/tb_alu_issue_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu sequencing front end.
// - Datapath and register-file sizes.
// - FSM state encoding.
// - {S,Cin} function codes understood by the external alu.
package alu_pkg;

   localparam int unsigned DW      = 8;
   localparam int unsigned NREG    = 4;
   localparam int unsigned RegIdxW = 2;
   localparam int unsigned OpW     = 6;
   localparam int unsigned SW      = 5;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StExec = 2'b01,
      StWb   = 2'b10
   } state_e;

   // Function codes {S,Cin}. The sequencer passes these through undecoded;
   // any code not listed makes the alu produce zero.
   localparam logic [OpW-1:0] OpPassA    = 6'b000000;
   localparam logic [OpW-1:0] OpInc      = 6'b000001;
   localparam logic [OpW-1:0] OpAdd      = 6'b000010;
   localparam logic [OpW-1:0] OpAddInc   = 6'b000011;
   localparam logic [OpW-1:0] OpAddNotB  = 6'b000100;
   localparam logic [OpW-1:0] OpSub      = 6'b000101;
   localparam logic [OpW-1:0] OpDec      = 6'b000110;
   localparam logic [OpW-1:0] OpPassA2   = 6'b000111;
   localparam logic [OpW-1:0] OpAnd      = 6'b001000;
   localparam logic [OpW-1:0] OpOr       = 6'b001010;
   localparam logic [OpW-1:0] OpXor      = 6'b001100;
   localparam logic [OpW-1:0] OpNotA     = 6'b001110;
   localparam logic [OpW-1:0] OpShl      = 6'b010000;
   localparam logic [OpW-1:0] OpShr      = 6'b100000;
   localparam logic [OpW-1:0] OpZero     = 6'b110000;

endpackage

// File: rtl/alu_regfile.sv
// NREG x DW register file for the alu sequencer.
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all entries)
//   raddr_a_i/rdata_a_o  combinational read port A
//   raddr_b_i/rdata_b_o  combinational read port B
//   we_i/waddr_i/wdata_i synchronous write port
module alu_regfile
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [RegIdxW-1:0] raddr_a_i,
   output logic [DW-1:0]      rdata_a_o,
   input  logic [RegIdxW-1:0] raddr_b_i,
   output logic [DW-1:0]      rdata_b_o,
   input  logic               we_i,
   input  logic [RegIdxW-1:0] waddr_i,
   input  logic [DW-1:0]      wdata_i
);

   logic [DW-1:0] rf_q [NREG];
   logic [DW-1:0] rf_d [NREG];

   always_comb begin
      for (int i = 0; i < int'(NREG); i++) begin
         rf_d[i] = rf_q[i];
      end
      if (we_i) begin
         rf_d[waddr_i] = wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NREG); i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   assign rdata_a_o = rf_q[raddr_a_i];
   assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/alu_issue_seq.sv
// Sequencing front end for the 8-bit combinational alu.
// Accepts one instruction per valid/ready handshake, reads operands from a
// local register file, drives registered S/Cin/A/B to the alu, captures Y,
// writes it back and presents it downstream with a zero flag.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        instruction handshake
//   in_op, in_load, in_rd, in_ra, in_rb, in_imm_sel, in_imm   instruction fields
//   alu_s, alu_cin, alu_a, alu_b   registered alu inputs
//   alu_y                    alu result
//   out_valid/out_ready      result handshake
//   out_data, out_rd, out_zero     result, destination, zero flag
module alu_issue_seq
   import alu_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [OpW-1:0]     in_op,
   input  logic               in_load,
   input  logic [RegIdxW-1:0] in_rd,
   input  logic [RegIdxW-1:0] in_ra,
   input  logic [RegIdxW-1:0] in_rb,
   input  logic               in_imm_sel,
   input  logic [DW-1:0]      in_imm,
   output logic [SW-1:0]      alu_s,
   output logic               alu_cin,
   output logic [DW-1:0]      alu_a,
   output logic [DW-1:0]      alu_b,
   input  logic [DW-1:0]      alu_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      out_data,
   output logic [RegIdxW-1:0] out_rd,
   output logic               out_zero
);

   state_e              state_q, state_d;
   logic [SW-1:0]       alu_s_q, alu_s_d;
   logic                alu_cin_q, alu_cin_d;
   logic [DW-1:0]       alu_a_q, alu_a_d;
   logic [DW-1:0]       alu_b_q, alu_b_d;
   logic [RegIdxW-1:0]  rd_q, rd_d;
   logic                load_q, load_d;
   logic [DW-1:0]       imm_q, imm_d;
   logic                out_valid_q, out_valid_d;
   logic [DW-1:0]       out_data_q, out_data_d;
   logic [RegIdxW-1:0]  out_rd_q, out_rd_d;

   logic [DW-1:0]       rdata_a, rdata_b;
   logic                rf_we;
   logic [DW-1:0]       wb_data;

   alu_regfile u_regfile (
      .clk       (clk),
      .rst       (rst),
      .raddr_a_i (in_ra),
      .rdata_a_o (rdata_a),
      .raddr_b_i (in_rb),
      .rdata_b_o (rdata_b),
      .we_i      (rf_we),
      .waddr_i   (rd_q),
      .wdata_i   (wb_data)
   );

   // Loads bypass the alu; the same value feeds the result register and the
   // register-file write so both update on the end-of-EXEC edge.
   assign wb_data = load_q ? imm_q : alu_y;

   always_comb begin
      state_d     = state_q;
      alu_s_d     = alu_s_q;
      alu_cin_d   = alu_cin_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      rd_d        = rd_q;
      load_d      = load_q;
      imm_d       = imm_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_rd_d    = out_rd_q;
      rf_we       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               alu_s_d   = in_op[OpW-1:1];
               alu_cin_d = in_op[0];
               alu_a_d   = rdata_a;
               alu_b_d   = in_imm_sel ? in_imm : rdata_b;
               rd_d      = in_rd;
               load_d    = in_load;
               imm_d     = in_imm;
               state_d   = StExec;
            end
         end
         StExec: begin
            out_data_d  = wb_data;
            out_rd_d    = rd_q;
            out_valid_d = 1'b1;
            rf_we       = 1'b1;
            state_d     = StWb;
         end
         StWb: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Reset wins over any accept or write-back on the same edge; the register
   // file sees the same reset so an aborted EXEC never lands its write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         alu_s_q     <= '0;
         alu_cin_q   <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         rd_q        <= '0;
         load_q      <= 1'b0;
         imm_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_rd_q    <= '0;
      end else begin
         state_q     <= state_d;
         alu_s_q     <= alu_s_d;
         alu_cin_q   <= alu_cin_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         rd_q        <= rd_d;
         load_q      <= load_d;
         imm_q       <= imm_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_rd_q    <= out_rd_d;
      end
   end

   assign in_ready  = (state_q == StIdle) && !rst;
   assign alu_s     = alu_s_q;
   assign alu_cin   = alu_cin_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_rd    = out_rd_q;
   assign out_zero  = (out_data_q == '0);

endmodule

// File: tb/tb_alu_issue_seq.sv
// Self-checking bench for alu_issue_seq with a behavioural alu beside it.
module tb_alu_issue_seq;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_op;
   logic       in_load;
   logic [1:0] in_rd, in_ra, in_rb;
   logic       in_imm_sel;
   logic [7:0] in_imm;
   logic [4:0] alu_s;
   logic       alu_cin;
   logic [7:0] alu_a, alu_b, alu_y;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [1:0] out_rd;
   logic       out_zero;

   int checks;
   int failures;

   alu_issue_seq dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_load    (in_load),
      .in_rd      (in_rd),
      .in_ra      (in_ra),
      .in_rb      (in_rb),
      .in_imm_sel (in_imm_sel),
      .in_imm     (in_imm),
      .alu_s      (alu_s),
      .alu_cin    (alu_cin),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_y      (alu_y),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_rd     (out_rd),
      .out_zero   (out_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_f(input logic [4:0] s, input logic cin,
                                        input logic [7:0] a, input logic [7:0] b);
      logic [7:0] r;
      case ({s, cin})
         6'b000000: r = a;
         6'b000001: r = 8'(a + 8'd1);
         6'b000010: r = 8'(a + b);
         6'b000011: r = 8'(a + b + 8'd1);
         6'b000100: r = 8'(a + ~b);
         6'b000101: r = 8'(a - b);
         6'b000110: r = 8'(a - 8'd1);
         6'b000111: r = a;
         6'b001000: r = a & b;
         6'b001010: r = a | b;
         6'b001100: r = a ^ b;
         6'b001110: r = ~a;
         6'b010000: r = {a[6:0], 1'b0};
         6'b100000: r = {1'b0, a[7:1]};
         default:   r = 8'h00;
      endcase
      return r;
   endfunction

   always_comb alu_y = alu_f(alu_s, alu_cin, alu_a, alu_b);

   typedef struct {
      logic       ld;
      logic [5:0] op;
      logic [1:0] rd;
      logic [1:0] ra;
      logic [1:0] rb;
      logic       isel;
      logic [7:0] imm;
      logic [7:0] exp_data;
      logic       exp_zero;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   function automatic vec_t mk(input logic ld, input logic [5:0] op, input logic [1:0] rd,
                               input logic [1:0] ra, input logic [1:0] rb, input logic isel,
                               input logic [7:0] imm, input logic [7:0] ed, input logic ez);
      vec_t v;
      v.ld = ld; v.op = op; v.rd = rd; v.ra = ra; v.rb = rb;
      v.isel = isel; v.imm = imm; v.exp_data = ed; v.exp_zero = ez;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Offer one instruction, then wait (bounded) for out_valid. lat counts
   // rising edges from the accept edge up to the edge that raised out_valid.
   task automatic issue(input logic ld, input logic [5:0] op, input logic [1:0] rd,
                        input logic [1:0] ra, input logic [1:0] rb, input logic isel,
                        input logic [7:0] imm, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check("in_ready_before_issue", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_load = ld; in_op = op; in_rd = rd; in_ra = ra;
      in_rb = rb; in_imm_sel = isel; in_imm = imm;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic retire();
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      checks = 0;
      failures = 0;
      rst = 1'b1; in_valid = 1'b0; in_op = '0; in_load = 1'b0; in_rd = '0;
      in_ra = '0; in_rb = '0; in_imm_sel = 1'b0; in_imm = '0; out_ready = 1'b1;

      vecs[0]  = mk(1, 6'b000000, 2'd1, 2'd0, 2'd0, 0, 8'h05, 8'h05, 0);
      vecs[1]  = mk(1, 6'b000000, 2'd2, 2'd0, 2'd0, 0, 8'h03, 8'h03, 0);
      vecs[2]  = mk(0, 6'b000010, 2'd3, 2'd1, 2'd2, 0, 8'h00, 8'h08, 0);
      vecs[3]  = mk(0, 6'b000101, 2'd3, 2'd1, 2'd1, 0, 8'h00, 8'h00, 1);
      vecs[4]  = mk(0, 6'b000000, 2'd0, 2'd3, 2'd0, 0, 8'h00, 8'h00, 1);
      vecs[5]  = mk(1, 6'b000000, 2'd0, 2'd0, 2'd0, 0, 8'hFF, 8'hFF, 0);
      vecs[6]  = mk(0, 6'b000001, 2'd0, 2'd0, 2'd0, 0, 8'h00, 8'h00, 1);
      vecs[7]  = mk(0, 6'b000010, 2'd0, 2'd0, 2'd3, 1, 8'h80, 8'h80, 0);
      vecs[8]  = mk(0, 6'b001000, 2'd3, 2'd2, 2'd1, 0, 8'h00, 8'h01, 0);
      vecs[9]  = mk(0, 6'b001100, 2'd3, 2'd2, 2'd1, 0, 8'h00, 8'h06, 0);
      vecs[10] = mk(0, 6'b001110, 2'd3, 2'd1, 2'd0, 0, 8'h00, 8'hFA, 0);
      vecs[11] = mk(0, 6'b010000, 2'd3, 2'd1, 2'd0, 0, 8'h00, 8'h0A, 0);
      vecs[12] = mk(0, 6'b100000, 2'd3, 2'd1, 2'd0, 0, 8'h00, 8'h02, 0);
      vecs[13] = mk(0, 6'b000110, 2'd0, 2'd0, 2'd0, 0, 8'h00, 8'h7F, 0);
      vecs[14] = mk(0, 6'b000100, 2'd3, 2'd1, 2'd2, 0, 8'h00, 8'h01, 0);
      vecs[15] = mk(0, 6'b001010, 2'd3, 2'd1, 2'd2, 0, 8'h00, 8'h07, 0);
      vecs[16] = mk(1, 6'b000000, 2'd3, 2'd0, 2'd0, 0, 8'h5A, 8'h5A, 0);
      vecs[17] = mk(0, 6'b001001, 2'd3, 2'd3, 2'd0, 0, 8'h00, 8'h00, 1);
      vecs[18] = mk(0, 6'b000000, 2'd0, 2'd3, 2'd0, 0, 8'h00, 8'h00, 1);

      repeat (3) @(posedge clk);
      #1;
      check("in_ready_during_rst", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_rd", 32'(out_rd), 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd1);
      check("rst_alu_regs", {alu_s, alu_cin, alu_a, alu_b}, 32'd0);
      rst = 1'b0;
      #1;
      check("in_ready_after_rst", 32'(in_ready), 32'd1);

      for (int i = 0; i < NVEC; i++) begin
         issue(vecs[i].ld, vecs[i].op, vecs[i].rd, vecs[i].ra, vecs[i].rb,
               vecs[i].isel, vecs[i].imm, lat);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
         check($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         check($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
         check($sformatf("v%0d_zero", i), 32'(out_zero), 32'(vecs[i].exp_zero));
         retire();
      end

      // Back-pressure in WB: r1=0x05, r2=0x03 still hold here.
      out_ready = 1'b0;
      issue(0, 6'b000010, 2'd3, 2'd1, 2'd2, 0, 8'h00, lat);
      check("stall_latency", 32'(lat), 32'd2);
      check("stall_data0", 32'(out_data), 32'h08);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         check($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
         check($sformatf("stall%0d_data", c), 32'(out_data), 32'h08);
         check($sformatf("stall%0d_rd", c), 32'(out_rd), 32'd3);
         check($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("post_stall_in_ready", 32'(in_ready), 32'd1);
      check("post_stall_valid", 32'(out_valid), 32'd0);
      issue(0, 6'b000011, 2'd3, 2'd1, 2'd2, 0, 8'h00, lat);
      check("post_stall_latency", 32'(lat), 32'd2);
      check("post_stall_data", 32'(out_data), 32'h09);
      retire();

      // Reset during EXEC of a load to r2 (r2 is 0x03 beforehand).
      check("pre_abort_in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1; in_load = 1'b1; in_op = 6'b000000; in_rd = 2'd2;
      in_ra = 2'd0; in_rb = 2'd0; in_imm_sel = 1'b0; in_imm = 8'h77;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("abort_in_exec_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_out_valid", 32'(out_valid), 32'd0);
      check("abort_in_ready_rst_high", 32'(in_ready), 32'd0);
      check("abort_out_zero", 32'(out_zero), 32'd1);
      check("abort_alu_a", 32'(alu_a), 32'd0);
      rst = 1'b0;
      #1;
      check("abort_in_ready_after", 32'(in_ready), 32'd1);
      issue(0, 6'b000000, 2'd0, 2'd2, 2'd0, 0, 8'h00, lat);
      check("abort_r2_cleared", 32'(out_data), 32'h00);
      check("abort_r2_zero", 32'(out_zero), 32'd1);
      retire();
      issue(0, 6'b000000, 2'd0, 2'd1, 2'd0, 0, 8'h00, lat);
      check("abort_r1_cleared", 32'(out_data), 32'h00);
      retire();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
